// File: rtl/note_pkg.sv
// Shared note definitions: one-hot note codes, pitch table, half-period helper, envelope states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package note_pkg;

    localparam int W_NOTE = 12;
    localparam int W_HP   = 20;

    // One-hot note codes, bit 11 = C down to bit 0 = B
    localparam logic [W_NOTE-1:0] NOTE_C  = 12'b1000_0000_0000;
    localparam logic [W_NOTE-1:0] NOTE_CS = 12'b0100_0000_0000;
    localparam logic [W_NOTE-1:0] NOTE_D  = 12'b0010_0000_0000;
    localparam logic [W_NOTE-1:0] NOTE_DS = 12'b0001_0000_0000;
    localparam logic [W_NOTE-1:0] NOTE_E  = 12'b0000_1000_0000;
    localparam logic [W_NOTE-1:0] NOTE_F  = 12'b0000_0100_0000;
    localparam logic [W_NOTE-1:0] NOTE_FS = 12'b0000_0010_0000;
    localparam logic [W_NOTE-1:0] NOTE_G  = 12'b0000_0001_0000;
    localparam logic [W_NOTE-1:0] NOTE_GS = 12'b0000_0000_1000;
    localparam logic [W_NOTE-1:0] NOTE_A  = 12'b0000_0000_0100;
    localparam logic [W_NOTE-1:0] NOTE_AS = 12'b0000_0000_0010;
    localparam logic [W_NOTE-1:0] NOTE_B  = 12'b0000_0000_0001;

    // Flat-name aliases
    localparam logic [W_NOTE-1:0] NOTE_DF = NOTE_CS;
    localparam logic [W_NOTE-1:0] NOTE_EF = NOTE_DS;
    localparam logic [W_NOTE-1:0] NOTE_GF = NOTE_FS;
    localparam logic [W_NOTE-1:0] NOTE_AF = NOTE_GS;
    localparam logic [W_NOTE-1:0] NOTE_BF = NOTE_AS;

    // Note frequencies in units of 0.01 Hz, indexed by one-hot bit position (0 = B .. 11 = C)
    localparam int unsigned freq_100 [W_NOTE] = '{
        49388, 46616, 44000, 41530, 39200, 36999,
        34923, 32963, 31113, 29366, 27718, 26163
    };

    typedef enum logic [1:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

    typedef logic [W_NOTE-1:0][W_HP-1:0] hp_tab_t;

    // Clock cycles per half waveform period; 0 for anything that is not exactly one-hot
    function automatic logic [W_HP-1:0] half_period(input logic [W_NOTE-1:0] note,
                                                    input logic [1:0]        octave,
                                                    input int unsigned       clk_mhz);
        logic [63:0] num;
        logic [63:0] q;
        num = 64'(clk_mhz) * 64'd100_000_000;
        q   = '0;
        for (int i = 0; i < W_NOTE; i++) begin
            if (note == (W_NOTE'(1) << i)) begin
                q = num / 64'(freq_100[i]);
            end
        end
        q = q >> (32'(octave) + 32'd1);
        return q[W_HP-1:0];
    endfunction

    // Octave-0 half-periods for every note; octave shifts are applied afterwards as a plain
    // right shift, which gives the same truncated result as shifting the full quotient.
    function automatic hp_tab_t base_half_periods(input int unsigned clk_mhz);
        hp_tab_t t;
        for (int i = 0; i < W_NOTE; i++) begin
            t[i] = half_period(W_NOTE'(1) << i, 2'd0, clk_mhz);
        end
        return t;
    endfunction

endpackage

// File: rtl/envelope_gen.sv
// Attack/sustain/release amplitude envelope with a free-running tick prescaler.
// Latency: amp and state update on the tick cycle; gate changes move the state next cycle.
// Backpressure: none; gate and tick_en are sampled every cycle.
module envelope_gen
    import note_pkg::*;
#(
    parameter logic [15:0] amp_max  = 16'h4000,
    parameter logic [15:0] amp_step = 16'h0040,
    parameter int unsigned env_div  = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gate,
    input  logic        tick_en,
    output logic [15:0] amp,
    output env_state_t  state
);

    localparam int PRE_W = (env_div > 1) ? $clog2(env_div) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(env_div - 1);

    env_state_t       state_nxt;
    logic [15:0]      amp_nxt;
    logic [15:0]      amp_up;
    logic [15:0]      amp_dn;
    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_nxt;
    logic             tick;

    assign tick = tick_en && (state != ENV_IDLE) && (pre == PRE_MAX);

    // State, amplitude and prescaler registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ENV_IDLE;
            amp   <= '0;
            pre   <= '0;
        end else begin
            state <= state_nxt;
            amp   <= amp_nxt;
            pre   <= pre_nxt;
        end
    end

    // Next state and amplitude: ramps move only on ticks, gate changes act at once
    always_comb begin
        state_nxt = state;
        amp_nxt   = amp;
        case (state)
            ENV_IDLE: begin
                if (gate) state_nxt = ENV_ATTACK;
            end
            ENV_ATTACK: begin
                if (!gate) begin
                    state_nxt = ENV_RELEASE;
                end else if (tick) begin
                    amp_nxt = amp_up;
                    if (amp_up == amp_max) state_nxt = ENV_SUSTAIN;
                end
            end
            ENV_SUSTAIN: begin
                if (!gate) state_nxt = ENV_RELEASE;
            end
            ENV_RELEASE: begin
                if (gate) begin
                    state_nxt = ENV_ATTACK;
                end else if (tick) begin
                    amp_nxt = amp_dn;
                    if (amp_dn == 16'h0) state_nxt = ENV_IDLE;
                end
            end
            default: state_nxt = ENV_IDLE;
        endcase
    end

    // Saturating ramp steps and prescaler advance (held at 0 in and on entry to IDLE)
    always_comb begin
        logic [16:0] sum;
        sum    = {1'b0, amp} + {1'b0, amp_step};
        amp_up = (sum >= {1'b0, amp_max}) ? amp_max : sum[15:0];
        amp_dn = (amp <= amp_step) ? 16'h0 : (amp - amp_step);
        if ((state == ENV_IDLE) || (state_nxt == ENV_IDLE)) begin
            pre_nxt = '0;
        end else if (tick_en) begin
            pre_nxt = (pre == PRE_MAX) ? '0 : (pre + PRE_W'(1));
        end else begin
            pre_nxt = pre;
        end
    end

endmodule

// File: rtl/note_synth.sv
// Square-wave tone generator: one-hot note + octave in, enveloped 24-bit samples out.
// Latency: 1 cycle input register, new note starts next cycle from IDLE, 1 cycle output register.
// Backpressure: none; a sample is produced every cycle.
module note_synth
    import note_pkg::*;
#(
    parameter int unsigned clk_mhz  = 50,
    parameter logic [15:0] amp_max  = 16'h4000,
    parameter logic [15:0] amp_step = 16'h0040,
    parameter int unsigned env_div  = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_NOTE-1:0] i_note,
    input  logic [1:0]        i_octave,
    output logic [23:0]       o_sample,
    output logic              o_active,
    output logic [W_NOTE-1:0] o_cur_note
);

    localparam hp_tab_t HP_BASE = base_half_periods(clk_mhz);

    logic [W_NOTE-1:0] note_q;
    logic [1:0]        oct_q;
    logic              note_vld;
    logic [W_HP-1:0]   hp_sel;
    logic [W_HP-1:0]   hp_cur;
    logic [W_HP-1:0]   cnt;
    logic              phase;
    logic [W_NOTE-1:0] cur_note;
    logic [15:0]       amp;
    env_state_t        env_state;

    // Input register: note and octave are taken one cycle after they are presented
    always_ff @(posedge clk) begin
        if (!rst) begin
            note_q <= '0;
            oct_q  <= '0;
        end else begin
            note_q <= i_note;
            oct_q  <= i_octave;
        end
    end

    assign note_vld = $onehot(note_q);

    // Half-period of the registered note/octave
    always_comb begin
        hp_sel = '0;
        for (int i = 0; i < W_NOTE; i++) begin
            if (note_q[i]) hp_sel = HP_BASE[i] >> oct_q;
        end
    end

    envelope_gen #(
        .amp_max  (amp_max),
        .amp_step (amp_step),
        .env_div  (env_div)
    ) u_env (
        .clk     (clk),
        .rst     (rst),
        .gate    (note_vld),
        .tick_en (1'b1),
        .amp     (amp),
        .state   (env_state)
    );

    // Tone counter: a running half-period always completes; new notes are adopted only at reload,
    // and with no valid note the last pitch keeps running through the release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            phase    <= 1'b0;
            cur_note <= '0;
            hp_cur   <= '0;
        end else if (env_state == ENV_IDLE) begin
            if (note_vld) begin
                cnt      <= hp_sel - W_HP'(1);
                phase    <= 1'b0;
                cur_note <= note_q;
                hp_cur   <= hp_sel;
            end else begin
                cnt      <= '0;
                phase    <= 1'b0;
                cur_note <= '0;
                hp_cur   <= '0;
            end
        end else if (cnt == '0) begin
            phase <= ~phase;
            if (note_vld) begin
                cnt      <= hp_sel - W_HP'(1);
                cur_note <= note_q;
                hp_cur   <= hp_sel;
            end else begin
                cnt <= hp_cur - W_HP'(1);
            end
        end else begin
            cnt <= cnt - W_HP'(1);
        end
    end

    // Output sample register: amplitude while phase is high, silence otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_sample <= '0;
        end else begin
            o_sample <= {(phase ? amp : 16'h0), 8'h00};
        end
    end

    assign o_active   = (env_state != ENV_IDLE);
    assign o_cur_note = o_active ? cur_note : '0;

endmodule

// File: doc/note_synth.md
Name: note_synth

Overview:
- Tone generator: converts a 12-bit one-hot note code plus an octave select into a square-wave audio sample stream.
- The envelope is shaped by an attack/sustain/release ramp.
- Output uses the same 24-bit sample format the note detector consumes on its mic input, so the synthesizer can drive speaker/DAC logic.
- It can also be looped back into the detector for self-test.

Parameters:
- clk_mhz, 50, system clock frequency in MHz; used to derive half-periods.
- amp_max, 16'h4000, sustain amplitude in sample[23:8] units.
- amp_step, 16'h0040, amplitude increment/decrement per envelope tick.
- env_div, 50000, clock cycles per envelope tick (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- i_note  in  12  one-hot note, bit 11 = C ... bit 0 = B; all-zero = no note
- i_octave  in  2  octave shift 0..3; frequency multiplied by 2^i_octave
- o_sample  out  24  audio sample; [23:8] = amplitude or 0, [7:0] = 0
- o_active  out  1  high whenever the state is not IDLE
- o_cur_note  out  12  one-hot note currently being generated (0 in IDLE)

Behaviour:
- Reset (rst==0 at posedge clk): state IDLE, amp=0, phase=0, half-period counter=0, prescaler=0, o_sample=0, o_active=0, o_cur_note=0. Reset overrides everything, mid-note included.
- Note validity:
  - i_note is valid only if exactly one bit is set.
  - Zero or multi-hot is treated as no note.
  - i_note/i_octave are sampled every cycle, registered once (1-cycle input latency).
- Half-period: hp = (clk_mhz*1_000_000*100 / freq_100[note]) >> (i_octave+1).
  - Integer division, truncating.
  - Computed from constant table; 20-bit result.
  - Example: A, octave 0: 5e9/44000 = 113636, hp = 56818.
- Tone counter:
  - Counts down from hp-1 to 0.
  - At 0: phase toggles and counter reloads with the current hp.
  - A note/octave change is taken only at reload: the running half-period always completes, so there are no glitches.
  - o_cur_note updates at that reload.
- FSM states: IDLE, ATTACK, SUSTAIN, RELEASE.
  - IDLE -> ATTACK on a valid note. Counter loads hp immediately, phase=0, o_cur_note=note.
  - ATTACK: on each envelope tick, amp = min(amp+amp_step, amp_max). When it reaches amp_max -> SUSTAIN.
  - SUSTAIN: amp held. No note -> RELEASE.
  - RELEASE: on each tick, amp = max(amp-amp_step, 0). On reaching 0 -> IDLE; phase, counter and o_cur_note are cleared.
  - A valid note in ATTACK or SUSTAIN keeps the state; a new note is picked up at the next reload.
  - A valid note in RELEASE -> ATTACK, ramping from the current amp (no restart from 0).
- Envelope prescaler:
  - Free-running 0..env_div-1 while the state is not IDLE; tick when it equals env_div-1.
  - Reset to 0 on IDLE entry.
  - The state transition and amp update happen in the same cycle as the tick.
- Arithmetic: amp is 16-bit; add/sub saturate at amp_max / 0. An amp_step that does not divide amp_max still saturates exactly to amp_max.
- Output: o_sample registered as {phase ? amp : 16'h0, 8'h00}; 1-cycle latency from phase/amp. o_active = (state != IDLE).

Decomposition:
- Package note_pkg:
  - w_note=12 and one-hot constants C..B plus aliases Df/Ef/Gf/Af/Bf.
  - freq_100 table (26163..49388).
  - Function half_period(note, octave, clk_mhz).
  - Envelope state enum.
- The detector also imports the one-hot constants and frequency table from note_pkg.
- Sub-module envelope_gen holds the prescaler, FSM and amp register. Inputs: gate, tick enable. Output: amp, state.
- note_synth holds the input register, half-period selection, tone counter and output register.

Test Plan:
- Reset/idle: hold rst=0 5 cycles, then i_note=0 for 1000 cycles -> o_sample=0, o_active=0, o_cur_note=0 throughout.
- A octave 0, env_div=10, amp_step=16'h1000, amp_max=16'h4000:
  - Phase toggles every 56818 cycles.
  - o_sample[23:8] steps 0x1000, 0x2000, 0x3000, 0x4000 on successive ticks during phase-high, then stays at 0x4000 (SUSTAIN).
- Octave/note change mid-half-period: switch A->C octave 1 at cycle 20000 of a half-period -> that half-period still lasts 56818; the next lasts 5e9/26163=191109 >>2 = 47777; o_cur_note changes at that reload.
- Release and retrigger:
  - Drop i_note to 0 in SUSTAIN -> amp falls 0x1000 per tick.
  - Reassert A when amp=0x2000 -> ATTACK resumes from 0x2000 and reaches 0x4000 after 2 ticks.
- Invalid code: i_note=12'b0000_0000_0101 in SUSTAIN -> treated as no note; RELEASE to IDLE, o_active drops after amp reaches 0.
- Loopback: feed o_sample to the detector with amp_max=16'h4000, note E octave 0 -> detector o_note=12'b0000_1000_0000 after its filter settles.
- Reset mid-ATTACK: rst=0 for 1 cycle -> next cycle all outputs 0, state IDLE.
